fft_sample_loader: RTL
======================

Name: fft_sample_loader

Overview:
Upstream input stage for top_fft_iter. It accepts a 16-bit word stream of complex samples, packs each sample into a 32-bit {re,im} word, and writes samples pairwise into the FFT RAM through the A/B write ports at bit-reversed addresses. After 2^AWL samples it pulses START, tracks o_RAM_BLOCK through the transform, and signals completion.

Parameters:
IWL, 32, packed complex sample width; re = [IWL-1:IWL/2], im = [IWL/2-1:0]; fixed at 32 with a 16-bit input word.
AWL, 7, FFT RAM address width; N = 2^AWL samples per frame.
BIT_REV, 1, 1 = A/B addresses are the AWL-bit reversal of the sample index; 0 = natural order.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous reset, active-low.
EN  in  1  clock enable; when low, all state holds.
i_CLR  in  1  synchronous frame abort; returns to LOAD with counters at 0.
i_DATA  in  16  input half-sample; real part first, then imaginary.
i_VALID  in  1  i_DATA valid.
o_READY  out  1  word accepted on a cycle where i_VALID & o_READY & EN.
o_A_DATA  out  IWL  even-index sample to the FFT RAM A port.
o_B_DATA  out  IWL  odd-index sample to the FFT RAM B port.
o_A_ADDR  out  AWL  A write address.
o_B_ADDR  out  AWL  B write address.
o_RAM_Wr  out  1  one-cycle dual write strobe (drives i_RAM_Wr).
o_START  out  1  one-cycle FFT start pulse.
i_RAM_BLOCK  in  1  FFT busy, from o_RAM_BLOCK.
o_DONE  out  1  one-cycle pulse when the FFT releases the RAM.
o_BUSY  out  1  high in every state except LOAD.

Behaviour:
- Reset (RST=0, async): state = LOAD; idx = 0; half = 0; all data/addr registers = 0; o_RAM_Wr = o_START = o_DONE = 0; o_READY = 1 once RST is released.
- States: LOAD, WRITE, START, WAIT_BUSY, WAIT_DONE.
- LOAD:
  - o_READY = ~i_RAM_BLOCK.
  - On accept with half = 0: latch re, set half = 1.
  - On accept with half = 1: latch im, set half = 0.
  - A completed sample goes to the A holding register if idx is even, or to the B holding register if idx is odd.
  - Completing an odd-idx sample -> WRITE.
- WRITE (1 cycle):
  - o_RAM_Wr = 1, o_READY = 0.
  - o_A_ADDR = rev(idx-1); o_B_ADDR = rev(idx) (rev = identity when BIT_REV = 0).
  - Example: AWL = 3, pair (6,7) -> A = 3, B = 7.
  - If idx = N-1: next state START, idx wraps to 0. Otherwise idx += 1 and return to LOAD.
- START (1 cycle): o_START = 1 -> WAIT_BUSY.
- WAIT_BUSY: stay until i_RAM_BLOCK = 1 -> WAIT_DONE.
- WAIT_DONE: stay while i_RAM_BLOCK = 1; on 0, o_DONE = 1 for 1 cycle -> LOAD.
- Latency: last imag word accepted at cycle t -> o_RAM_Wr at t+1 -> o_START at t+2.
- o_RAM_Wr, o_START and o_DONE are registered single-cycle pulses and are never high simultaneously.
- o_A/B_DATA and o_A/B_ADDR hold their last written values outside WRITE.
- EN = 0: state, counters and data hold; o_READY = 0; pulses forced to 0. A pending pulse is emitted on the first EN = 1 cycle.
- i_CLR = 1 (any state, EN = 1): next state LOAD, idx = 0, half = 0, pulses = 0; holding-register data is discarded. i_CLR has priority over every transition, including a WRITE in flight.
- Reset mid-frame: partial frame discarded; no o_START is issued.
- i_VALID during WRITE/START/WAIT_*: not accepted (o_READY = 0); the source must hold data.
- i_RAM_BLOCK high while in LOAD: o_READY = 0, stall without data loss.
- N = 2^AWL is always even, so a frame always ends on a complete pair.

Test Plan:
1. AWL=3, BIT_REV=1; stream samples k = 0..7 as re = 16*k, im = -k -> writes (A,B) = (0,4), (2,6), (1,5), (3,7); o_A_DATA for pair (2,3) = {16'h0020, 16'hFFFE}; o_START exactly 2 cycles after the 16th word is accepted.
2. Same as 1 with BIT_REV=0 -> addresses (0,1), (2,3), (4,5), (6,7); same data.
3. After o_START, model i_RAM_BLOCK high for 20 cycles -> o_BUSY high throughout, o_READY = 0, o_DONE one pulse the cycle after i_RAM_BLOCK falls, then new frame accepted.
4. i_VALID toggled randomly, EN low 3 cycles mid-pair -> no lost or duplicated words; RAM contents match the reference bit-reversed frame.
5. i_CLR after 5 samples, then full 8-sample frame -> first write of new frame at A = 0, B = 4 with new data; exactly one o_START.
6. RST asserted asynchronously during WAIT_BUSY -> outputs zero immediately; no o_DONE; the next frame behaves as in scenario 1.

Source files
------------

// File: rtl/fft_sample_loader.sv
// ---------------------------------------------------------------------------
// fft_sample_loader
//
// Input stage for the iterative FFT core. Takes a 16-bit half-sample stream
// (real part first, then imaginary) and packs each pair of words into one
// {re,im} sample. Samples are then written two at a time into the FFT RAM
// through its A/B write ports. The write addresses are either bit-reversed
// or in natural order. After a full frame of 2^AWL samples the block pulses
// START. It then follows the FFT busy flag, pulses DONE when the RAM is
// released, and goes back to loading.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous reset, active-low
//   EN           clock enable; all state holds while low
//   i_CLR        synchronous frame abort back to LOAD
//   i_DATA       16-bit half-sample (re word, then im word)
//   i_VALID      i_DATA valid
//   o_READY      word accepted when i_VALID & o_READY
//   o_A_DATA     even-index sample to the RAM A port
//   o_B_DATA     odd-index sample to the RAM B port
//   o_A_ADDR     A write address
//   o_B_ADDR     B write address
//   o_RAM_Wr     one-cycle dual write strobe
//   o_START      one-cycle FFT start pulse
//   i_RAM_BLOCK  FFT busy flag
//   o_DONE       one-cycle pulse when the FFT releases the RAM
//   o_BUSY       high in every state except LOAD
// ---------------------------------------------------------------------------
module fft_sample_loader #(
    parameter int IWL     = 32,
    parameter int AWL     = 7,
    parameter bit BIT_REV = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic           i_CLR,
    input  logic [15:0]    i_DATA,
    input  logic           i_VALID,
    output logic           o_READY,
    output logic [IWL-1:0] o_A_DATA,
    output logic [IWL-1:0] o_B_DATA,
    output logic [AWL-1:0] o_A_ADDR,
    output logic [AWL-1:0] o_B_ADDR,
    output logic           o_RAM_Wr,
    output logic           o_START,
    input  logic           i_RAM_BLOCK,
    output logic           o_DONE,
    output logic           o_BUSY
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_WRITE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t             state;
    logic [AWL-1:0]     idx;
    logic               half;
    logic [IWL/2-1:0]   re_hold;
    logic [IWL-1:0]     a_hold;
    logic [IWL-1:0]     sample_w;
    logic               wr_q;
    logic               start_q;
    logic               done_q;
    logic               accept;

    function automatic logic [AWL-1:0] addr_map(input logic [AWL-1:0] a);
        logic [AWL-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < AWL; i++) begin
            r[i] = a[AWL-1-i];
        end
        return BIT_REV ? r : a;
    endfunction

    assign sample_w = {re_hold, i_DATA};
    assign o_READY  = RST & EN & (state == S_LOAD) & ~i_RAM_BLOCK;
    assign accept   = i_VALID & o_READY;
    assign o_BUSY   = (state != S_LOAD);

    // Pulse registers hold their value while EN is low and are masked at
    // the output, so a pending pulse appears on the first enabled cycle.
    assign o_RAM_Wr = wr_q & EN;
    assign o_START  = start_q & EN;
    assign o_DONE   = done_q & EN;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_LOAD;
            idx      <= '0;
            half     <= 1'b0;
            re_hold  <= '0;
            a_hold   <= '0;
            o_A_DATA <= '0;
            o_B_DATA <= '0;
            o_A_ADDR <= '0;
            o_B_ADDR <= '0;
            wr_q     <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else if (EN) begin
            wr_q    <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (i_CLR) begin
                state   <= S_LOAD;
                idx     <= '0;
                half    <= 1'b0;
                re_hold <= '0;
                a_hold  <= '0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (accept) begin
                            if (!half) begin
                                re_hold <= i_DATA;
                                half    <= 1'b1;
                            end else begin
                                half <= 1'b0;
                                if (!idx[0]) begin
                                    a_hold <= sample_w;
                                    idx    <= idx + AWL'(1);
                                end else begin
                                    // The odd sample goes straight to the B
                                    // output. idx is odd here, so idx-1 is
                                    // idx with its LSB cleared.
                                    o_A_DATA <= a_hold;
                                    o_B_DATA <= sample_w;
                                    o_A_ADDR <= addr_map({idx[AWL-1:1], 1'b0});
                                    o_B_ADDR <= addr_map(idx);
                                    wr_q     <= 1'b1;
                                    state    <= S_WRITE;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        if (idx == '1) begin
                            idx     <= '0;
                            start_q <= 1'b1;
                            state   <= S_START;
                        end else begin
                            idx   <= idx + AWL'(1);
                            state <= S_LOAD;
                        end
                    end
                    S_START: begin
                        state <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY: begin
                        if (i_RAM_BLOCK) begin
                            state <= S_WAIT_DONE;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (!i_RAM_BLOCK) begin
                            done_q <= 1'b1;
                            state  <= S_LOAD;
                        end
                    end
                    default: begin
                        state <= S_LOAD;
                    end
                endcase
            end
        end
    end

endmodule
